// File: rtl/tag_read_issuer_if.sv
// Host request, AXI AR and metadata-FIFO signals of the DRAM-cache tag read front end.
// slave is the issuer's view; master is the view of whatever drives it.
interface tag_read_issuer_if #(
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready (req_*, ar*);
   // once valid is high it and its payload hold until ready; valid never waits on ready.
   logic                req_valid_i;
   logic                req_ready_o;
   logic [63:0]         req_addr_i;
   logic                req_write_i;
   logic [15:0]         req_id_i;
   logic [ID_WIDTH-1:0] arid_o;
   logic [63:0]         araddr_o;
   logic [7:0]          arlen_o;
   logic [2:0]          arsize_o;
   logic [1:0]          arburst_o;
   logic                arvalid_o;
   logic                arready_i;
   logic [80:0]         fifo_data_o;
   logic                fifo_valid_o;
   logic                fifo_pop_i;
   logic [CW-1:0]       fifo_count_o;
   logic                dbg_state_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_write_i, req_id_i, arready_i, fifo_pop_i,
      output req_ready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
             fifo_data_o, fifo_valid_o, fifo_count_o, dbg_state_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_write_i, req_id_i, arready_i, fifo_pop_i,
      input  req_ready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
             fifo_data_o, fifo_valid_o, fifo_count_o, dbg_state_o
   );
endinterface

// File: rtl/tag_read_issuer.sv
// Turns each host access into one AXI AR line fetch and queues its 81-bit metadata
// in an in-order FIFO, so AR order and FIFO order always match.
module tag_read_issuer #(
   parameter int ID_WIDTH   = 4,
   parameter int SET_BITS   = 20,
   parameter int BURST_LEN  = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   tag_read_issuer_if.slave    bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ID_WIDTH-1:0] r_arid;
   logic [63:0]         r_araddr;
   logic [80:0]         r_entry;
   logic [80:0]         r_mem [FIFO_DEPTH];
   logic [AW:0]         r_wptr;
   logic [AW:0]         r_rptr;
   logic [CW-1:0]       r_count;

   logic w_not_full;
   logic w_room_b2b;
   logic w_ar_hs;
   logic w_ready;
   logic w_accept;
   logic w_push;
   logic w_pop;

   // Ready ignores same-cycle pops; back-to-back acceptance needs room for the AR
   // being retired now plus the new one.
   always_comb begin
      w_not_full = (r_count < CW'(FIFO_DEPTH));
      w_room_b2b = (r_count < CW'(FIFO_DEPTH - 1));
      w_ar_hs    = (r_state == S_ISSUE) && bus.arready_i;
      w_ready    = !rst && (((r_state == S_IDLE) && w_not_full) || (w_ar_hs && w_room_b2b));
      w_accept   = bus.req_valid_i && w_ready;
      w_push     = w_ar_hs;
      w_pop      = bus.fifo_pop_i && (r_count != '0);
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
         S_ISSUE: if (w_ar_hs && !w_accept) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_arid   <= '0;
         r_araddr <= '0;
         r_entry  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_araddr <= {{(64 - SET_BITS - 6){1'b0}}, bus.req_addr_i[SET_BITS+5:6], 6'b0};
            r_entry  <= {bus.req_write_i, bus.req_id_i, bus.req_addr_i};
         end
         if (w_ar_hs) r_arid <= r_arid + ID_WIDTH'(1);
         if (w_push)  r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)   r_rptr <= r_rptr + (AW+1)'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; the empty check below masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= r_entry;
   end

   assign bus.req_ready_o  = w_ready;
   assign bus.arvalid_o    = (r_state == S_ISSUE);
   assign bus.arid_o       = r_arid;
   assign bus.araddr_o     = r_araddr;
   assign bus.arlen_o      = 8'(BURST_LEN - 1);
   assign bus.arsize_o     = 3'd6;
   assign bus.arburst_o    = 2'b01;
   assign bus.fifo_valid_o = (r_count != '0);
   assign bus.fifo_data_o  = (r_count != '0) ? r_mem[r_rptr[AW-1:0]] : '0;
   assign bus.fifo_count_o = r_count;
   assign bus.dbg_state_o  = (r_state == S_ISSUE);

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && !w_not_full));
endmodule

// File: tb/tb_tag_read_issuer.sv
// Directed bench for tag_read_issuer: a small AR/FIFO model checks every cycle,
// plus explicit checks of the hand-computed vectors.
module tb_tag_read_issuer;
   localparam int ID_WIDTH   = 4;
   localparam int SET_BITS   = 20;
   localparam int BURST_LEN  = 2;
   localparam int FIFO_DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tag_read_issuer_if #(.ID_WIDTH(ID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   tag_read_issuer #(
      .ID_WIDTH(ID_WIDTH), .SET_BITS(SET_BITS), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [80:0]         pend_q[$];
   logic [80:0]         exp_q[$];
   logic [ID_WIDTH-1:0] ar_seen_q[$];
   logic [ID_WIDTH-1:0] exp_id;
   int                  n_acc;
   int                  n_hs;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] set_addr(input logic [63:0] a);
      return {38'd0, a[25:6], 6'd0};
   endfunction

   function automatic logic [63:0] gen_addr(input int k);
      return 64'h0000_0001_0000_0003 + 64'(k) * 64'h1040;
   endfunction

   task automatic drive_idle();
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_write_i = 1'b0;
      bus.req_id_i    = '0;
      bus.arready_i   = 1'b0;
      bus.fifo_pop_i  = 1'b0;
   endtask

   // Called at a falling edge; applies inputs, checks against the model, advances one clock.
   task automatic cycle(input bit v, input logic [63:0] a, input bit w, input logic [15:0] id,
                        input bit ar, input bit pop);
      bit          acc, hs, pp, mready;
      logic [80:0] moved;
      bus.req_valid_i = v;
      bus.req_addr_i  = a;
      bus.req_write_i = w;
      bus.req_id_i    = id;
      bus.arready_i   = ar;
      bus.fifo_pop_i  = pop;
      #1;
      mready = ((pend_q.size() == 0) && (exp_q.size() < FIFO_DEPTH)) ||
               ((pend_q.size() != 0) && ar && (exp_q.size() < FIFO_DEPTH - 1));
      check("arvalid", bus.arvalid_o, pend_q.size() != 0);
      check("count", bus.fifo_count_o, exp_q.size());
      check("fifo_valid", bus.fifo_valid_o, exp_q.size() != 0);
      check("req_ready", bus.req_ready_o, mready);
      hs = (pend_q.size() != 0) && ar;
      if (pend_q.size() != 0) begin
         check("araddr", bus.araddr_o, set_addr(pend_q[0][63:0]));
         check("arid", bus.arid_o, exp_id);
      end
      pp = pop && (exp_q.size() != 0);
      if (pp) check("fifo_data", bus.fifo_data_o, exp_q[0]);
      acc = v && mready;
      if (hs) ar_seen_q.push_back(bus.arid_o);
      @(posedge clk);
      if (pp) void'(exp_q.pop_front());
      if (hs) begin
         moved = pend_q.pop_front();
         exp_q.push_back(moved);
         exp_id = exp_id + ID_WIDTH'(1);
         n_hs++;
      end
      if (acc) begin
         pend_q.push_back({w, id, a});
         n_acc++;
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arvalid"}, bus.arvalid_o, 1'b0);
      check({tag, "_arid"}, bus.arid_o, '0);
      check({tag, "_araddr"}, bus.araddr_o, 64'd0);
      check({tag, "_count"}, bus.fifo_count_o, 0);
      check({tag, "_fifo_valid"}, bus.fifo_valid_o, 1'b0);
      check({tag, "_fifo_data"}, bus.fifo_data_o, 81'd0);
      check({tag, "_req_ready"}, bus.req_ready_o, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      pend_q.delete();
      exp_q.delete();
      ar_seen_q.delete();
      exp_id = '0;
      n_acc  = 0;
      n_hs   = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive_idle();
      do_reset();

      // Reset values and constant AR fields
      rst = 1'b1;
      #1;
      check_reset_outputs("reset");
      check("arlen", bus.arlen_o, 8'd1);
      check("arsize", bus.arsize_o, 3'd6);
      check("arburst", bus.arburst_o, 2'b01);
      @(negedge clk);
      rst = 1'b0;

      // Single read
      cycle(1, 64'h0000_0000_1234_5678, 0, 16'hA5A5, 1, 0);
      check("t1_arvalid", bus.arvalid_o, 1'b1);
      check("t1_araddr", bus.araddr_o, 64'h0000_0000_0234_5640);
      check("t1_arid", bus.arid_o, 4'd0);
      check("t1_arlen", bus.arlen_o, 8'd1);
      cycle(0, 64'd0, 0, 16'd0, 1, 0);
      check("t1_fifo_data", bus.fifo_data_o, {1'b0, 16'hA5A5, 64'h0000_0000_1234_5678});
      check("t1_count", bus.fifo_count_o, 1);
      cycle(0, 64'd0, 0, 16'd0, 0, 1);

      // AR backpressure for 5 cycles
      cycle(1, 64'hFFFF_0000_ABCD_EF40, 1, 16'h0001, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("bp_arvalid", bus.arvalid_o, 1'b1);
         check("bp_araddr", bus.araddr_o, 64'h0000_0000_03CD_EF40);
         check("bp_arid", bus.arid_o, 4'd1);
         check("bp_count", bus.fifo_count_o, 0);
         cycle(1, 64'h0000_0000_0000_0080, 0, 16'h0002, 0, 0);
      end
      cycle(0, 64'd0, 0, 16'd0, 1, 0);
      check("bp_fifo_data", bus.fifo_data_o, {1'b1, 16'h0001, 64'hFFFF_0000_ABCD_EF40});
      cycle(0, 64'd0, 0, 16'd0, 0, 1);

      // Fill without pops: 9 requests, only 8 fit
      do_reset();
      for (int i = 0; i < 12; i++)
         cycle(1, gen_addr(n_acc), n_acc[0], 16'(16'h100 + n_acc), 1, 0);
      check("fill_count", bus.fifo_count_o, 8);
      check("fill_req_ready", bus.req_ready_o, 1'b0);
      check("fill_ar_count", ar_seen_q.size(), 8);
      check("fill_last_id", ar_seen_q[ar_seen_q.size()-1], 4'd7);
      cycle(1, gen_addr(8), 0, 16'h0108, 1, 1);
      cycle(1, gen_addr(8), 0, 16'h0108, 1, 0);
      cycle(0, 64'd0, 0, 16'd0, 1, 0);
      check("fill_ninth_id", ar_seen_q[ar_seen_q.size()-1], 4'd8);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         cycle(0, 64'd0, 0, 16'd0, 0, 1);
      check("fill_drained", bus.fifo_count_o, 0);

      // ID wrap: 17 requests with continuous pops
      do_reset();
      for (int i = 0; i < 60 && n_acc < 17; i++)
         cycle(1, gen_addr(n_acc + 32), 0, 16'(16'h200 + n_acc), 1, 1);
      repeat (3) cycle(0, 64'd0, 0, 16'd0, 1, 1);
      check("wrap_ar_count", ar_seen_q.size(), 17);
      check("wrap_id15", ar_seen_q[15], 4'd15);
      check("wrap_id16", ar_seen_q[16], 4'd0);

      // Concurrent push and pop at count 1, then pop on empty
      do_reset();
      cycle(1, 64'h0000_0000_0000_1000, 0, 16'h0AAA, 1, 0);
      cycle(0, 64'd0, 0, 16'd0, 1, 0);
      cycle(1, 64'h0000_0000_0000_2040, 1, 16'h0BBB, 1, 0);
      cycle(0, 64'd0, 0, 16'd0, 1, 1);
      check("pp_count", bus.fifo_count_o, 1);
      check("pp_head", bus.fifo_data_o, {1'b1, 16'h0BBB, 64'h0000_0000_0000_2040});
      cycle(0, 64'd0, 0, 16'd0, 0, 1);
      cycle(0, 64'd0, 0, 16'd0, 0, 1);
      check("empty_pop_count", bus.fifo_count_o, 0);
      check("empty_pop_valid", bus.fifo_valid_o, 1'b0);

      // Reset mid-burst with count 3 and an AR pending
      do_reset();
      cycle(1, gen_addr(40), 0, 16'h0300, 0, 0);
      cycle(1, gen_addr(41), 0, 16'h0301, 1, 0);
      cycle(1, gen_addr(42), 0, 16'h0302, 1, 0);
      cycle(1, gen_addr(43), 0, 16'h0303, 1, 0);
      cycle(0, 64'd0, 0, 16'd0, 0, 0);
      check("mid_count", bus.fifo_count_o, 3);
      check("mid_arvalid", bus.arvalid_o, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      do_reset();
      cycle(1, 64'h0000_0000_0000_5000, 0, 16'h0400, 0, 0);
      check("post_reset_arid", bus.arid_o, 4'd0);
      check("post_reset_arvalid", bus.arvalid_o, 1'b1);
      cycle(0, 64'd0, 0, 16'd0, 1, 0);
      cycle(0, 64'd0, 0, 16'd0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/tag_read_issuer.md
# tag_read_issuer

Request-side front end of the DRAM cache. Each host access (read or write) turns into an AXI AR burst that fetches the tag + data line of the target set from DRAM. An 81-bit metadata entry for the access is queued in an in-order FIFO. The tag comparator pops that FIFO as the matching R data arrives, so AR issue order and FIFO order are identical by construction.

## Interface
Parameters:
- ID_WIDTH, 4, AXI arid width; IDs are allocated round-robin.
- SET_BITS, 20, number of set-index bits taken from address bits [SET_BITS+5:6].
- BURST_LEN, 2, beats per line fetch (tag beat + data beat); drives arlen_o = BURST_LEN-1.
- FIFO_DEPTH, 8, metadata FIFO entries; must be a power of two, ≥2; also the outstanding-fetch limit.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  host request accepted when valid&&ready.
- req_addr_i  in  64  host byte address.
- req_write_i  in  1  1 = write access, 0 = read access.
- req_id_i  in  16  host transaction tag, returned in metadata.
- arid_o  out  ID_WIDTH  AXI AR id.
- araddr_o  out  64  AXI AR address.
- arlen_o  out  8  constant BURST_LEN-1.
- arsize_o  out  3  constant 3'd6 (64-byte beats).
- arburst_o  out  2  constant 2'b01 (INCR).
- arvalid_o  out  1  AXI AR valid.
- arready_i  in  1  AXI AR ready.
- fifo_data_o  out  81  head entry: [80] write flag, [79:64] req_id, [63:0] address.
- fifo_valid_o  out  1  FIFO non-empty.
- fifo_pop_i  in  1  comparator consumes head entry.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- FSM states:
  - S_IDLE: no AR pending.
  - S_ISSUE: AR held on the bus.
- Accept in S_IDLE when req_valid_i && count < FIFO_DEPTH. The block then:
  - latches araddr_o = {zeros, req_addr_i[SET_BITS+5:6], 6'b0};
  - latches the entry {req_write_i, req_id_i, req_addr_i};
  - moves to S_ISSUE.
- S_ISSUE: arvalid_o=1; arid_o/araddr_o stay stable until arready_i. On the handshake the block:
  - pushes the latched entry into the FIFO;
  - increments the ID counter (modulo 2^ID_WIDTH, wraps 2^ID_WIDTH-1 → 0);
  - returns to S_IDLE, or stays in S_ISSUE with the new request latched if back-to-back acceptance occurs.
- req_ready_o is combinational:
  - (S_IDLE && count<FIFO_DEPTH) || (S_ISSUE && arready_i && count<FIFO_DEPTH-1);
  - it is 0 while rst is high;
  - pops in the same cycle are not credited (conservative).
- FIFO:
  - circular buffer, write/read pointers one bit wider than the index;
  - full when count==FIFO_DEPTH, empty when count==0.
- Simultaneous push and pop: count unchanged; data order preserved. With count==1, a pop and push in the same cycle leaves the new entry at head next cycle.
- fifo_pop_i while empty is ignored: no pointer or count change.
- Push never occurs when full; the ready logic guarantees this. An assertion flags a violation.
- Reset, any time including mid-burst, forces:
  - state=S_IDLE, arvalid_o=0, arid_o=0, araddr_o=0;
  - FIFO pointers and count = 0, fifo_valid_o=0, fifo_data_o=0.
- A pending AR is dropped by reset.

## Timing
- Request accepted at edge N → arvalid_o=1 from cycle N+1.
- AR handshake at edge M → entry visible: fifo_valid_o=1, fifo_data_o valid from cycle M+1; fifo_count_o updates at M+1.
- Sustained throughput with arready_i tied high: one AR per cycle, via back-to-back acceptance in S_ISSUE.
- fifo_data_o reflects the head entry combinationally from the registered storage/pointer; a pop at edge P presents the next entry at P+1.
- AXI rule: once arvalid_o rises, it and all AR fields hold until arready_i. arvalid_o never depends combinationally on arready_i.

## Test plan
- Single read: req addr=64'h0000_0000_1234_5678, write=0, id=16'hA5A5, arready_i high → araddr_o=64'h0000_0000_0234_5640, arid_o=0, arlen_o=1 one cycle after accept; fifo_data_o={1'b0,16'hA5A5,64'h12345678} the cycle after the handshake.
- AR backpressure: arready_i low 5 cycles → arvalid_o and araddr_o stable for all 5; req_ready_o=0; no FIFO push until the handshake.
- Fill without pops: 9 back-to-back requests, arready_i high, FIFO_DEPTH=8 → exactly 8 ARs (ids 0..7); req_ready_o=0 with count=8; the 9th is accepted only after one pop.
- ID wrap: 17 requests with pops keeping the FIFO non-full → arid_o sequence 0..15,0; FIFO entries match AR order.
- Concurrent push+pop at count=1 → count stays 1, head becomes the new entry; pop on empty → count stays 0.
- Reset asserted while arvalid_o=1 and count=3 → all outputs at reset values immediately (async); after release the first request gets arid_o=0.
